fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Generates the PC and issues requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents {pc, instruction} to the decode stage (the if_id_type fields).
- Handles branch/jump redirects from EX, including discard of in-flight stale responses, and back-pressure from the hazard unit.

Parameters:
FIFO_DEPTH  4  prefetch FIFO entries; power of 2, >= 2; also the cap on in-flight plus buffered words.
RESET_PC  32'h0000_0000  first fetch address after reset.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; always word-aligned.
imem_gnt  input  1  request accepted this cycle when imem_req & imem_gnt.
imem_rvalid  input  1  response word valid; responses return in order, latency >= 1 cycle.
imem_rdata  input  32  response instruction word.
redirect_valid  input  1  branch/jump taken, from EX.
redirect_pc  input  32  new fetch target.
id_ready  input  1  decode can accept; low = stall.
if_id_valid  output  1  if_id_pc / if_id_instruction hold a real instruction.
if_id_pc  output  32  PC of the presented instruction.
if_id_instruction  output  32  instruction word, bit layout of instruction_type.

Behaviour:
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next accepted response.
  - outstanding: 0..FIFO_DEPTH, granted requests not yet answered.
  - discard_cnt: 0..FIFO_DEPTH, stale responses still to drop.
  - FIFO: {pc, instr} entries, with count.
- Reset (sync, active-high): fetch_pc = resp_pc = RESET_PC; outstanding, discard_cnt and FIFO count cleared; imem_req = 0; if_id_valid = 0. Reset overrides every other input.
- Request rule:
  - imem_req = !reset & !redirect_valid & (outstanding + fifo_count < FIFO_DEPTH).
  - imem_addr = fetch_pc.
  - On req & gnt: fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- Response rule (imem_rvalid):
  - Always decrements outstanding.
  - If discard_cnt > 0: word dropped, discard_cnt -= 1.
  - Otherwise: push {resp_pc, imem_rdata}, then resp_pc += 4.
  - The credit rule guarantees the FIFO is never full on a push; a push into a full FIFO is an assertion failure.
- Output:
  - Combinational from the FIFO head; if_id_valid = (fifo_count != 0).
  - When empty: if_id_instruction = 32'h0000_0013 (addi x0,x0,0 NOP) and if_id_pc = 0.
  - Pop when if_id_valid & id_ready.
  - If id_ready is low, outputs stay stable.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (highest priority after reset), in the cycle redirect_valid = 1:
  - No request is issued.
  - FIFO flushed; no pop is counted.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - discard_cnt = outstanding - imem_rvalid.
  - A response arriving in this cycle is dropped.
  - if_id_valid = 0 from the next cycle until new data arrives.
- Back-to-back redirects: each one recomputes discard_cnt from the current outstanding value; only the last target survives.
- Latency, zero-wait memory (gnt = 1, rvalid one cycle after grant):
  - Redirect at cycle T: request at T+1, rvalid at T+2, if_id_valid at T+3.
  - In steady state with id_ready = 1: one instruction per cycle. FIFO_DEPTH >= 2 is required to sustain this.
- Counters must never under/overflow.
- Responses issued before a reset must not arrive after it; this is a system requirement on the memory model.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_fetched (32): counts pops to decode.
  - perf_discarded (32): counts dropped responses plus FIFO entries flushed by a redirect.
- Both counters clear on reset and wrap modulo 2^32.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, gnt = 1, 1-cycle memory, id_ready = 1 -> imem_addr 0x0, 0x4, 0x8, ...; if_id_valid first high 2 cycles after the first request; if_id_pc 0x0 with its word, then 0x4.
- id_ready low for 10 cycles -> imem_req drops once outstanding + count = 4; outputs stay frozen at the same pc; no word lost or duplicated after release.
- Redirect to 0x100 with 2 in flight, memory latency 3 -> both stale words dropped; next if_id_pc = 0x100; no NOP-free gap contains an old PC.
- Redirect to 0x203 -> imem_addr = 0x200; if_id_pc = 0x200.
- Redirect in the same cycle as rvalid, then a second redirect one cycle later to 0x400 -> only 0x400-stream instructions reach decode; discard_cnt returns to 0.
- imem_gnt held low 5 cycles after redirect -> fetch_pc held; outstanding unchanged; FIFO empty; if_id_instruction = 0x00000013 and if_id_valid = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, imem requests, prefetch FIFO feeding decode.
// Latency: redirect at T -> request T+1 -> if_id_valid T+3 (zero-wait memory); 1 instr/cycle steady.
// Backpressure: id_ready low holds the head; requests stop once in-flight + buffered reach FIFO_DEPTH.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt     request handshake (addr always word-aligned)
//   imem_rvalid/imem_rdata          in-order responses, latency >= 1
//   redirect_valid/redirect_pc      taken branch/jump from EX
//   id_ready                        decode can accept the head entry
//   if_id_valid/if_id_pc/if_id_instruction  head of the prefetch FIFO (NOP, pc 0 when empty)
//   perf_fetched/perf_discarded     only with FETCH_PERF_CNT_EN defined
module fetch_stage #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int unsigned  PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned  CW        = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [31:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0]  RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];

    logic [CW:0]   in_use;
    logic          credit_ok;
    logic          req_fire;
    logic          fifo_full;
    logic          accept_word;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;
    logic [CW-1:0] outstanding_dec;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] fifo_count_nxt;

    // Branch targets are forced to word alignment; the low bits are intentionally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[31:2], 2'b00};

    // Credit: every granted request owns a FIFO slot, so a response can always be pushed.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = in_use < {1'b0, DEPTH_C};
    assign imem_req  = !reset && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;

    assign fifo_full   = (fifo_count == DEPTH_C);
    assign accept_word = imem_rvalid && !redirect_valid && (discard_cnt == '0);
    assign push        = accept_word && !fifo_full;

    assign if_id_valid       = !reset && (fifo_count != '0);
    assign if_id_pc          = if_id_valid ? fifo_pc[rd_ptr]    : 32'd0;
    assign if_id_instruction = if_id_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
    // A redirect flushes the head instead of handing it to decode.
    assign pop = if_id_valid && id_ready && !redirect_valid;

    // Saturating decrement guards against a spurious rvalid with nothing in flight.
    assign outstanding_dec = (imem_rvalid && (outstanding != '0)) ? outstanding - CW'(1) : outstanding;
    assign outstanding_nxt = outstanding_dec + CW'(req_fire);
    assign fifo_count_nxt  = fifo_count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC_ALIGNED;
            resp_pc     <= RESET_PC_ALIGNED;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc    <= redirect_target;
                resp_pc     <= redirect_target;
                // Everything still in flight after this cycle belongs to the old stream.
                discard_cnt <= outstanding_dec;
                fifo_count  <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (imem_rvalid && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                fifo_count <= fifo_count_nxt;
            end
        end
    end

    // Storage needs no reset: fifo_count qualifies every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept_word) begin
                assert (!fifo_full);
            end
            if (imem_rvalid) begin
                assert (outstanding != '0);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        drop_word;
    logic [31:0] flushed_words;

    assign drop_word     = imem_rvalid && (redirect_valid || (discard_cnt != '0));
    assign flushed_words = redirect_valid ? 32'(fifo_count) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= 32'd0;
            perf_discarded <= 32'd0;
        end else begin
            perf_fetched   <= perf_fetched + 32'(pop);
            perf_discarded <= perf_discarded + 32'(drop_word) + flushed_words;
        end
    end
`endif

endmodule
